twofish_subkey_gen: RTL and testbench

- Sequential Twofish round-subkey generator for 128-bit keys (k=2), downstream of the key schedule that splits the key into Me/Mo.
- Accepts a key through a valid/ready handshake and computes K0..K39 pair by pair.
- Uses one shared h-function core and streams each 32-bit subkey out with backpressure to the round datapath.

---
 rtl/twofish_pkg.sv | 55 +++++
 rtl/twofish_h_core.sv | 44 ++++
 rtl/twofish_subkey_gen.sv | 151 +++++++++++++++
 tb/tb_twofish_subkey_gen.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twofish_pkg.sv
// Shared constants and helpers for the Twofish subkey generator:
// q-permutation t-tables, MDS matrix, GF(2^8) polynomials and the FSM state type.
package twofish_pkg;

    localparam logic [31:0] RHO          = 32'h01010101;
    localparam logic [8:0]  GF_MDS_POLY  = 9'h169;
    localparam logic [8:0]  GF_RS_POLY   = 9'h14D;

    // Nibble substitution tables t0..t3 for q0 and q1.
    localparam logic [3:0] Q0_T [4][16] = '{
        '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2, 4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4},
        '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5, 4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD},
        '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0, 4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1},
        '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE, 4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA}
    };

    localparam logic [3:0] Q1_T [4][16] = '{
        '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE, 4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5},
        '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7, 4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8},
        '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA, 4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF},
        '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE, 4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA}
    };

    localparam logic [7:0] MDS [4][4] = '{
        '{8'h01, 8'hEF, 8'h5B, 8'h5B},
        '{8'h5B, 8'hEF, 8'hEF, 8'h01},
        '{8'hEF, 8'h5B, 8'h01, 8'hEF},
        '{8'hEF, 8'h01, 8'hEF, 8'h5B}
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC_A,
        ST_CALC_B,
        ST_EMIT_E,
        ST_EMIT_O,
        ST_DONE
    } subkey_state_t;

    // Shift-and-add multiply in GF(2^8) reduced by the given 9-bit polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic [8:0] poly);
        logic [7:0] acc;
        logic [8:0] sh;
        acc = 8'h00;
        sh  = {1'b0, a};
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh[7:0];
            sh = {sh[7:0], 1'b0};
            if (sh[8]) sh = sh ^ poly;
        end
        return acc;
    endfunction

endpackage

// File: rtl/twofish_h_core.sv
// Combinational Twofish h-function for a 128-bit key (two 32-bit key words):
// three q-permutation layers with key mixing, then the MDS multiply.
module twofish_h_core
    import twofish_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] l0,
    input  logic [31:0] l1,
    output logic [31:0] z
);

    function automatic logic [7:0] q_perm(input logic use_q1, input logic [7:0] v);
        logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
        a0 = v[7:4];
        b0 = v[3:0];
        a1 = a0 ^ b0;
        b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
        a2 = use_q1 ? Q1_T[0][a1] : Q0_T[0][a1];
        b2 = use_q1 ? Q1_T[1][b1] : Q0_T[1][b1];
        a3 = a2 ^ b2;
        b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
        a4 = use_q1 ? Q1_T[2][a3] : Q0_T[2][a3];
        b4 = use_q1 ? Q1_T[3][b3] : Q0_T[3][b3];
        return {b4, a4};
    endfunction

    logic [3:0][7:0] y;

    // NOTE: every variable driven here is fully assigned on every pass, so no latch is inferred.
    always_comb begin
        y[0] = q_perm(1'b1, q_perm(1'b0, q_perm(1'b0, x[7:0])   ^ l1[7:0])   ^ l0[7:0]);
        y[1] = q_perm(1'b0, q_perm(1'b0, q_perm(1'b1, x[15:8])  ^ l1[15:8])  ^ l0[15:8]);
        y[2] = q_perm(1'b1, q_perm(1'b1, q_perm(1'b0, x[23:16]) ^ l1[23:16]) ^ l0[23:16]);
        y[3] = q_perm(1'b0, q_perm(1'b1, q_perm(1'b1, x[31:24]) ^ l1[31:24]) ^ l0[31:24]);

        z = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                z[8*r +: 8] = z[8*r +: 8] ^ gf_mul(MDS[r][c], y[c], GF_MDS_POLY);
            end
        end
    end

endmodule

// File: rtl/twofish_subkey_gen.sv
// Sequential Twofish K0..K39 generator for 128-bit keys, one shared h core, streamed with backpressure.
// Define TWOFISH_SUBKEY_STORE_EN to add a readable 40-word subkey store and store_full flag.
module twofish_subkey_gen
    import twofish_pkg::*;
#(
    parameter int NUM_SUBKEYS = 40
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         sk_valid,
    input  logic         sk_ready,
    output logic [5:0]   sk_idx,
    output logic [31:0]  sk_data,
    output logic         done
`ifdef TWOFISH_SUBKEY_STORE_EN
    ,
    input  logic [5:0]   rd_idx,
    output logic [31:0]  rd_data,
    output logic         store_full
`endif
);

    localparam logic [4:0] LAST_PAIR = 5'(NUM_SUBKEYS / 2 - 1);

    subkey_state_t state;
    logic [4:0]    pair;
    logic [31:0]   me0, me1, mo0, mo1;
    logic [31:0]   a_reg, b_reg;

    logic [5:0]    h_step;
    logic [31:0]   h_x, h_l0, h_l1, h_z;
    logic [31:0]   b_next, odd_sum, odd_word;

    // CALC_A evaluates h on the even step with Me, CALC_B on the odd step with Mo.
    always_comb begin
        h_step   = {pair, state == ST_CALC_B};
        h_x      = RHO * 32'(h_step);
        h_l0     = (state == ST_CALC_B) ? mo0 : me0;
        h_l1     = (state == ST_CALC_B) ? mo1 : me1;
        b_next   = {h_z[23:0], h_z[31:24]};
        odd_sum  = a_reg + {b_reg[30:0], 1'b0};
        odd_word = {odd_sum[22:0], odd_sum[31:23]};
    end

    twofish_h_core u_h_core (
        .x  (h_x),
        .l0 (h_l0),
        .l1 (h_l1),
        .z  (h_z)
    );

    assign key_ready = (state == ST_IDLE) && !rst;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pair     <= '0;
            me0      <= '0;
            me1      <= '0;
            mo0      <= '0;
            mo1      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            sk_valid <= 1'b0;
            sk_idx   <= '0;
            sk_data  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        me0   <= key[31:0];
                        mo0   <= key[63:32];
                        me1   <= key[95:64];
                        mo1   <= key[127:96];
                        pair  <= '0;
                        state <= ST_CALC_A;
                    end
                end
                ST_CALC_A: begin
                    a_reg <= h_z;
                    state <= ST_CALC_B;
                end
                ST_CALC_B: begin
                    b_reg    <= b_next;
                    sk_data  <= a_reg + b_next;
                    sk_idx   <= {pair, 1'b0};
                    sk_valid <= 1'b1;
                    state    <= ST_EMIT_E;
                end
                ST_EMIT_E: begin
                    if (sk_ready) begin
                        sk_data <= odd_word;
                        sk_idx  <= {pair, 1'b1};
                        state   <= ST_EMIT_O;
                    end
                end
                ST_EMIT_O: begin
                    if (sk_ready) begin
                        sk_valid <= 1'b0;
                        if (pair == LAST_PAIR) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            pair  <= pair + 5'd1;
                            state <= ST_CALC_A;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TWOFISH_SUBKEY_STORE_EN
    localparam logic [5:0] NUM_IDX = 6'(NUM_SUBKEYS);

    logic [31:0] store_mem [NUM_SUBKEYS];

    // NOTE: the store is deliberately not reset; store_full says when its contents are meaningful.
    always_ff @(posedge clk) begin
        if (sk_valid && sk_ready) begin
            store_mem[sk_idx] <= sk_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_full <= 1'b0;
        end else if (state == ST_IDLE && key_valid) begin
            store_full <= 1'b0;
        end else if (state == ST_EMIT_O && sk_ready && pair == LAST_PAIR) begin
            store_full <= 1'b1;
        end
    end

    assign rd_data = (rd_idx < NUM_IDX) ? store_mem[rd_idx] : 32'h0;
`endif

endmodule

// File: tb/tb_twofish_subkey_gen.sv
// Self-checking bench for twofish_subkey_gen against a table-driven software Twofish subkey model.
// Store checks are compiled in when TWOFISH_SUBKEY_STORE_EN is defined.
module tb_twofish_subkey_gen;

    localparam logic [31:0] TB_RHO = 32'h01010101;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         sk_valid;
    logic         sk_ready;
    logic [5:0]   sk_idx;
    logic [31:0]  sk_data;
    logic         done;
`ifdef TWOFISH_SUBKEY_STORE_EN
    logic [5:0]   rd_idx;
    logic [31:0]  rd_data;
    logic         store_full;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_k [40];
    logic [31:0] got   [40];

    int m_q [2][256];
    int qt [2][4][16] = '{
        '{'{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
          '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
          '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
          '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}},
        '{'{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
          '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
          '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
          '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}}
    };
    // q choice per byte lane: innermost, middle, outermost (0 = q0, 1 = q1).
    int q_order [4][3] = '{'{0,0,1}, '{1,0,0}, '{0,1,1}, '{1,1,0}};
    int mds [4][4] = '{'{'h01,'hEF,'h5B,'h5B}, '{'h5B,'hEF,'hEF,'h01},
                       '{'hEF,'h5B,'h01,'hEF}, '{'hEF,'h01,'hEF,'h5B}};

    twofish_subkey_gen dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .sk_valid   (sk_valid),
        .sk_ready   (sk_ready),
        .sk_idx     (sk_idx),
        .sk_data    (sk_data),
        .done       (done)
`ifdef TWOFISH_SUBKEY_STORE_EN
        ,
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .store_full (store_full)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic init_model();
        int a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 256; x++) begin
                a0 = x / 16;  b0 = x % 16;
                a1 = a0 ^ b0;
                b1 = (a0 ^ (((b0 >> 1) | (b0 << 3)) & 15) ^ ((a0 * 8) % 16)) & 15;
                a2 = qt[s][0][a1]; b2 = qt[s][1][b1];
                a3 = a2 ^ b2;
                b3 = (a2 ^ (((b2 >> 1) | (b2 << 3)) & 15) ^ ((a2 * 8) % 16)) & 15;
                a4 = qt[s][2][a3]; b4 = qt[s][3][b3];
                m_q[s][x] = b4 * 16 + a4;
            end
        end
    endtask

    function automatic int m_gmul(int a, int b);
        int p = 0;
        for (int k = 0; k < 8; k++) begin
            if (((b >> k) & 1) != 0) p = p ^ a;
            a = a * 2;
            if (a >= 256) a = a ^ 'h169;
        end
        return p & 255;
    endfunction

    function automatic logic [31:0] m_rol(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] m_h(logic [31:0] x, logic [31:0] l0, logic [31:0] l1);
        int y [4];
        int zb;
        logic [31:0] z = 0;
        for (int j = 0; j < 4; j++) begin
            y[j] = m_q[q_order[j][0]][(x >> (8*j)) & 255];
            y[j] = m_q[q_order[j][1]][y[j] ^ ((l1 >> (8*j)) & 255)];
            y[j] = m_q[q_order[j][2]][y[j] ^ ((l0 >> (8*j)) & 255)];
        end
        for (int r = 0; r < 4; r++) begin
            zb = 0;
            for (int c = 0; c < 4; c++) zb = zb ^ m_gmul(mds[r][c], y[c]);
            z = z | (32'(zb) << (8*r));
        end
        return z;
    endfunction

    task automatic model_key(input logic [127:0] k);
        logic [31:0] a, b, t;
        for (int i = 0; i < 20; i++) begin
            a = m_h(32'(2*i) * TB_RHO, k[31:0], k[95:64]);
            b = m_rol(m_h(32'(2*i + 1) * TB_RHO, k[63:32], k[127:96]), 8);
            exp_k[2*i] = a + b;
            t = a + b * 2;
            exp_k[2*i + 1] = m_rol(t, 9);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic start_key(input logic [127:0] k);
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_key_ready: key_ready=%b expected 1", key_ready);
        end
        key_valid = 1'b1;
        key       = k;
    endtask

    // Consumes one subkey stream, checking order, data and hold-under-stall.
    task automatic run_stream(input string name, input bit rnd, input int abort_idx,
                              input int inject_idx, input logic [127:0] inj_key,
                              output int first_cyc, output int last_cyc);
        int n = 0;
        int cyc = 0;
        bit stalled = 0;
        bit aborted = 0;
        logic [5:0]  h_idx = 0;
        logic [31:0] h_data = 0;
        first_cyc = -1;
        last_cyc  = -1;
        while (n < 40 && cyc < 1000 && !aborted) begin
            @(negedge clk);
            cyc++;
            key_valid = 1'b0;
            checks++;
            if (key_ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy: key_ready=%b done=%b expected 0/0 at cycle %0d",
                         name, key_ready, done, cyc);
            end
            if (stalled) begin
                checks++;
                if (sk_valid !== 1'b1 || sk_idx !== h_idx || sk_data !== h_data) begin
                    errors++;
                    $display("FAIL %s_hold: valid=%b idx=%0d data=%h expected 1/%0d/%h",
                             name, sk_valid, sk_idx, sk_data, h_idx, h_data);
                end
            end
            if (sk_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                checks++;
                if (sk_idx !== 6'(n)) begin
                    errors++;
                    $display("FAIL %s_idx: got %0d expected %0d", name, sk_idx, n);
                end
                checks++;
                if (sk_data !== exp_k[n]) begin
                    errors++;
                    $display("FAIL %s_data[%0d]: got %h expected %h", name, n, sk_data, exp_k[n]);
                end
                got[n] = sk_data;
                if (n == abort_idx) begin
                    rst      = 1'b1;
                    sk_ready = 1'b0;
                    aborted  = 1;
                end else begin
                    if (n == inject_idx) begin
                        key_valid = 1'b1;
                        key       = inj_key;
                    end
                    sk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (sk_ready) begin
                        n++;
                        stalled  = 0;
                        last_cyc = cyc;
                    end else begin
                        stalled = 1;
                        h_idx   = sk_idx;
                        h_data  = sk_data;
                    end
                end
            end
        end
        if (!aborted && n < 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: received %0d words expected 40", name, n);
        end
    endtask

    task automatic expect_done(input string name);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || sk_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b sk_valid=%b expected 1/0", name, done, sk_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_after: done=%b key_ready=%b expected 0/1", name, done, key_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (key_ready !== 1'b0 || sk_valid !== 1'b0 || sk_idx !== 6'd0 ||
            sk_data !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b idx=%0d data=%h done=%b expected 0/0/0/0/0",
                     key_ready, sk_valid, sk_idx, sk_data, done);
        end
`ifdef TWOFISH_SUBKEY_STORE_EN
        checks++;
        if (store_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_store_full: got %b expected 0", store_full);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", key_ready);
        end
    endtask

    task automatic test_zero_key();
        int fc, lc;
        model_key(128'h0);
        start_key(128'h0);
        run_stream("zero", 0, -1, -1, 128'h0, fc, lc);
        expect_done("zero");
        checks++;
        if (fc !== 3) begin
            errors++;
            $display("FAIL zero_latency: first valid at cycle %0d expected 3", fc);
        end
        checks++;
        if (lc !== 80) begin
            errors++;
            $display("FAIL zero_total: last handshake at cycle %0d expected 80", lc);
        end
        checks++;
        if (got[0] !== 32'h52C54DDE || got[1] !== 32'h11F0626D ||
            got[2] !== 32'h7CAC9D4A || got[3] !== 32'h4D1B4AAA) begin
            errors++;
            $display("FAIL zero_vectors: got %h %h %h %h expected 52c54dde 11f0626d 7cac9d4a 4d1b4aaa",
                     got[0], got[1], got[2], got[3]);
        end
`ifdef TWOFISH_SUBKEY_STORE_EN
        checks++;
        if (store_full !== 1'b1) begin
            errors++;
            $display("FAIL store_full_set: got %b expected 1", store_full);
        end
        rd_idx = 6'd1;
        #1;
        checks++;
        if (rd_data !== 32'h11F0626D) begin
            errors++;
            $display("FAIL store_rd1: got %h expected 11f0626d", rd_data);
        end
        rd_idx = 6'd45;
        #1;
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL store_rd45: got %h expected 0", rd_data);
        end
        for (int j = 0; j < 8; j++) begin
            rd_idx = 6'($urandom_range(0, 39));
            #1;
            checks++;
            if (rd_data !== exp_k[rd_idx]) begin
                errors++;
                $display("FAIL store_rd_rand[%0d]: got %h expected %h", rd_idx, rd_data, exp_k[rd_idx]);
            end
        end
`endif
    endtask

    task automatic test_stall();
        int fc, lc;
        model_key(128'h0);
        start_key(128'h0);
        run_stream("stall", 1, -1, -1, 128'h0, fc, lc);
        expect_done("stall");
    endtask

    task automatic test_ignore_key();
        int fc, lc;
        logic [127:0] first_key;
        first_key = {$urandom, $urandom, $urandom, $urandom};
        model_key(first_key);
        start_key(first_key);
        run_stream("ignore", 1, -1, 5, ~first_key, fc, lc);
        expect_done("ignore");
    endtask

    task automatic test_abort();
        int fc, lc;
        model_key(128'h0);
        start_key(128'h0);
        run_stream("abort", 1, 17, -1, 128'h0, fc, lc);
        @(negedge clk);
        checks++;
        if (sk_valid !== 1'b0 || done !== 1'b0 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: valid=%b done=%b ready=%b expected 0/0/0",
                     sk_valid, done, key_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (sk_valid !== 1'b0 || done !== 1'b0 || key_ready !== 1'b1) begin
                errors++;
                $display("FAIL abort_quiet: valid=%b done=%b ready=%b expected 0/0/1",
                         sk_valid, done, key_ready);
            end
        end
        start_key(128'h0);
        run_stream("abort_restart", 0, -1, -1, 128'h0, fc, lc);
        expect_done("abort_restart");
        checks++;
        if (got[0] !== 32'h52C54DDE) begin
            errors++;
            $display("FAIL abort_restart_k0: got %h expected 52c54dde", got[0]);
        end
    endtask

    task automatic test_back_to_back();
        int fc, lc;
        logic [127:0] k2;
        model_key(128'h0);
        start_key(128'h0);
        run_stream("b2b_zero", 0, -1, -1, 128'h0, fc, lc);
        expect_done("b2b_zero");
        k2 = 128'h0123456789ABCDEFFEDCBA9876543210;
        model_key(k2);
        start_key(k2);
        run_stream("b2b_second", 1, -1, -1, 128'h0, fc, lc);
        expect_done("b2b_second");
    endtask

    task automatic test_random_keys();
        int fc, lc;
        logic [127:0] k;
        for (int r = 0; r < 3; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_key(k);
            start_key(k);
            run_stream("rand_key", 1, -1, -1, 128'h0, fc, lc);
            expect_done("rand_key");
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key       = '0;
        sk_ready  = 1'b0;
`ifdef TWOFISH_SUBKEY_STORE_EN
        rd_idx    = '0;
`endif
        init_model();
        test_reset();
        test_zero_key();
        test_stall();
        test_ignore_key();
        test_abort();
        test_back_to_back();
        test_random_keys();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
